// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier that consumes one multiplier bit per clock.
// The product lands on op WIDTH cycles after start is accepted, with a one-cycle done pulse.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] op,
    output logic               busy,
    output logic               done
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [PW-1:0]  a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  acc_next;

    // a_reg shifts left and b_reg shifts right, so b_reg[0] is always the current bit.
    assign acc_next = acc + (b_reg[0] ? a_reg : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            op    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= PW'(a);
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        op    <= acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed scenarios plus random operands,
// compared against plain integer multiplication and the documented cycle timing.
module tb_seq_multiplier;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] op;
    logic           busy;
    logic           done;

    int vectors    = 0;
    int miscompares = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .op   (op),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned p;
        p = int'(x) * int'(y);
        return p[2*W-1:0];
    endfunction

    // Issue one operation from IDLE and check latency, busy span, held op, result and done width.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [2*W-1:0] expv, prev;
        int lat, busy_cnt;
        expv = ref_mul(x, y);
        @(negedge clk);
        prev  = op;
        start = 1'b1; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        lat = 0; busy_cnt = 0;
        while (!done && lat < 3 * W) begin
            if (busy) busy_cnt++;
            vectors++;
            if (op !== prev) begin
                miscompares++;
                $display("FAIL %s op_hold_run: got %h want %h", tag, op, prev);
            end
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== W) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, W);
        end
        vectors++;
        if (busy_cnt !== W || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_span: got %0d busy_end %b want %0d busy_end 0", tag, busy_cnt, busy, W);
        end
        vectors++;
        if (op !== expv) begin
            miscompares++;
            $display("FAIL %s product: got %h want %h", tag, op, expv);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || op !== expv || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: done %b busy %b op %h want 0 0 %h", tag, done, busy, op, expv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (op !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: op %h busy %b done %b want 0000 0 0", op, busy, done);
        end
        start = 1'b0; a = '0; b = '0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || op !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_no_start: op %h busy %b done %b want 0000 0 0", op, busy, done);
        end
    endtask

    task automatic test_basic();
        run_op(8'h5D, 8'hB5, "basic");
        repeat (3) @(negedge clk);
        vectors++;
        if (op !== 16'h41C1) begin
            miscompares++;
            $display("FAIL basic_hold: got %h want 41c1", op);
        end
    endtask

    task automatic test_extremes();
        run_op(8'hFF, 8'hFF, "ff_ff");
        run_op(8'h00, 8'hA7, "zero_a7");
        run_op(8'h80, 8'h02, "80_02");
        run_op(8'hA7, 8'h00, "a7_zero");
    endtask

    task automatic test_ignored_start();
        int lat;
        @(negedge clk);
        start = 1'b1; a = 8'h05; b = 8'h03;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h09; b = 8'h05;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        lat = 0;
        while (!done && lat < 3 * W) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (op !== 16'h000F || lat !== W - 3) begin
            miscompares++;
            $display("FAIL ignored_start_result: op %h lat %0d want 000f lat %0d", op, lat, W - 3);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || op !== 16'h000F) begin
            miscompares++;
            $display("FAIL ignored_start_queued: busy %b op %h want 0 000f", busy, op);
        end
        run_op(8'h09, 8'h05, "after_ignored");
    endtask

    task automatic test_held_start();
        int cyc, ndone, last;
        @(negedge clk);
        start = 1'b1; a = 8'h0C; b = 8'h0A;
        ndone = 0; last = -1;
        for (cyc = 0; cyc < 4 * (W + 1) && ndone < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                vectors++;
                if (op !== 16'h0078) begin
                    miscompares++;
                    $display("FAIL held_product: got %h want 0078", op);
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last !== W + 1) begin
                        miscompares++;
                        $display("FAIL held_interval: got %0d want %0d", cyc - last, W + 1);
                    end
                end
                last = cyc;
                ndone++;
            end
        end
        vectors++;
        if (ndone !== 3) begin
            miscompares++;
            $display("FAIL held_count: got %0d want 3", ndone);
        end
        start = 1'b0;
        // a restart may have been accepted on the last done edge; let it drain
        repeat (W + 2) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int seen;
        run_op(8'h5D, 8'hB5, "pre_reset");
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h77;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (op !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: op %h busy %b done %b want 0000 0 0", op, busy, done);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done || busy || op !== 16'h0000) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL midrun_idle: got %0d active cycles want 0", seen);
        end
        run_op(8'h12, 8'h34, "post_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op(W'($urandom), W'($urandom), "random");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_ignored_start();
        test_held_start();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Unsigned sequential shift-and-add multiplier: one multiplier bit per clock, 8 compute cycles for the default width.
- Operands are captured on a start request. The 2N-bit product is presented on op with a one-cycle done pulse.
- Used as a low-area arithmetic block where a single-cycle array multiplier is not needed.

Parameters:
- WIDTH, 8, operand width N in bits. Product width is 2*WIDTH. Legal range 2..32.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request to begin a multiplication. Level-sampled, honoured only in IDLE.
- a  input  WIDTH  multiplicand, unsigned. Sampled only on the accepting edge.
- b  input  WIDTH  multiplier, unsigned. Sampled only on the accepting edge.
- op  output  2*WIDTH  product register. Holds the last completed result.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high in the cycle in which op first shows a new result.

Behaviour:
- Reset: when rst_n is 0 at a rising edge:
  - op = 0, busy = 0, done = 0
  - internal accumulator, operand registers and counter = 0
  - state = IDLE
  - Reset overrides start and aborts a RUN in progress; no partial result reaches op.
- States: IDLE and RUN.
- IDLE:
  - On a rising edge with start = 1 (edge k): latch a into a_reg and b into b_reg, clear accumulator and bit counter, go to RUN, set busy = 1.
  - With start = 0: remain in IDLE; op holds its value.
- RUN, edges k+1 .. k+WIDTH, iteration i = 0..WIDTH-1:
  - If b_reg[i] = 1, accumulator += a_reg shifted left by i. All arithmetic is 2*WIDTH bits wide and overflow is impossible.
  - Equivalent shift-register forms (shift multiplicand left, or shift accumulator right) are acceptable if the external timing is identical.
  - At edge k+WIDTH: op <= final product, done <= 1, busy <= 0, state <= IDLE.
- Latency: result and done appear WIDTH edges after the accepting edge, i.e. 8 clocks for WIDTH = 8.
- done is high for exactly one cycle, then cleared at the next edge, including when a new start is accepted on that same edge.
- a and b may change or return to 0 after the accepting edge without affecting the result.
- start during RUN is ignored; it is not queued.
- If start is still 1 in IDLE after completion (at edge k+WIDTH+1), a new operation is accepted. Back-to-back operations therefore have a minimum issue interval of WIDTH+1 cycles.
- op keeps the previous result throughout RUN; it changes only on completion or reset.
- Zero operands still take the full WIDTH cycles. No early termination.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with start = 1, a = 0xFF, b = 0xFF -> op = 0x0000, busy = 0, done = 0; no operation starts.
- Basic: a = 0x5D, b = 0xB5, start = 1 for one accepting edge, then start, a and b = 0.
  - busy is high for 8 cycles.
  - At accept edge + 8: op = 0x41C1 (93*181 = 16833) and done pulses once.
  - op holds 0x41C1 afterwards.
- Extremes and unsigned check:
  - 0xFF * 0xFF -> op = 0xFE01
  - 0x00 * 0xA7 -> op = 0x0000, still done after 8 cycles
  - 0x80 * 0x02 -> op = 0x0100
- Ignored start: accept 0x05 * 0x03, pulse start with 0x09 * 0x05 during RUN.
  - op = 0x000F at completion; second request not executed.
  - Then issue 0x09 * 0x05 from IDLE -> op = 0x002D.
- Held start: keep start = 1 with a = 0x0C, b = 0x0A -> op = 0x0078 every 9 cycles, with done pulsing each completion.
- Reset mid-run: assert rst_n = 0 at cycle 4 of RUN after a prior result 0x41C1 -> op = 0x0000, busy = 0, state IDLE, no done pulse.
